// File: rtl/noc_credit_rx_buffer_if.sv
// Credit-based NoC link between a transmitter (or its pipeline stages) and the receive buffer.
// Packet layout is {last, addr, data}; the gnt vector carries credits back upstream.
interface noc_if #(
    parameter int VC_W = 2,
    parameter int A_W  = 8,
    parameter int D_W  = 8
);
    logic [VC_W-1:0]    credit_vc_target;
    logic [A_W+D_W:0]   credit_packet;
    logic [VC_W-1:0]    credit_vc_credit_gnt;

    modport transmitter (
        output credit_vc_target,
        output credit_packet,
        input  credit_vc_credit_gnt
    );

    modport receiver (
        input  credit_vc_target,
        input  credit_packet,
        output credit_vc_credit_gnt
    );
endinterface

// File: rtl/noc_credit_rx_buffer.sv
// Receive terminus of a credit-based NoC link: per-VC FIFOs, round-robin drain, one credit per pop.
// Optional macro NOC_CREDIT_RX_BUFFER_OCC_EN adds per-VC occupancy and high-water-mark outputs.
module noc_credit_rx_buffer #(
    parameter int  VC_W  = 2,
    parameter int  A_W   = 8,
    parameter int  D_W   = 8,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    noc_if.receiver          from_tx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VC_W-1:0]  out_vc,
    output logic [A_W-1:0]   out_addr,
    output logic [D_W-1:0]   out_data,
    output logic             out_last,
    output logic             err_overflow,
    output logic             err_multihot
`ifdef NOC_CREDIT_RX_BUFFER_OCC_EN
    ,
    output logic [VC_W-1:0][CNT_W-1:0] occupancy,
    output logic [VC_W-1:0][CNT_W-1:0] occ_max
`endif
);

    localparam int PKT_W = A_W + D_W + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;

    logic [PKT_W-1:0] mem [VC_W][DEPTH];
    logic [CNT_W-1:0] cnt     [VC_W];
    logic [CNT_W-1:0] cnt_nxt [VC_W];
    logic [PTR_W-1:0] wr_ptr  [VC_W];
    logic [PTR_W-1:0] rd_ptr  [VC_W];

    logic [IDX_W-1:0] rr_ptr, lock_idx, sel_idx, push_idx, hi_idx, lo_idx;
    logic             locked, found_hi, found_any;
    logic             pop, push_one, push_ok, multihot, overflow;
    logic [VC_W-1:0]  push_vec, pop_vec;
    logic [PKT_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Arbitration: a locked VC wins; otherwise first non-empty VC at or after rr_ptr, wrapping.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int v = 0; v < VC_W; v++) begin
            if (cnt[v] != '0) begin
                if (!found_any) begin
                    lo_idx    = IDX_W'(v);
                    found_any = 1'b1;
                end
                if (!found_hi && IDX_W'(v) >= rr_ptr) begin
                    hi_idx   = IDX_W'(v);
                    found_hi = 1'b1;
                end
            end
        end
        sel_idx = locked ? lock_idx : (found_hi ? hi_idx : lo_idx);
    end

    assign out_valid = locked || found_any;
    assign pop       = out_valid && out_ready;
    assign out_vc    = out_valid ? (VC_W'(1) << sel_idx) : '0;
    assign pop_vec   = pop ? out_vc : '0;

    assign head     = mem[sel_idx][rd_ptr[sel_idx]];
    assign out_last = head[PKT_W-1];
    assign out_addr = head[A_W+D_W-1:D_W];
    assign out_data = head[D_W-1:0];

    always_comb begin
        push_idx = '0;
        for (int v = 0; v < VC_W; v++) begin
            if (from_tx.credit_vc_target[v]) push_idx = IDX_W'(v);
        end
    end

    // A full FIFO still accepts a push when it is being popped in the same cycle.
    assign push_one = $onehot(from_tx.credit_vc_target);
    assign multihot = (from_tx.credit_vc_target != '0) && !push_one;
    assign push_ok  = push_one && ((cnt[push_idx] != CNT_W'(DEPTH)) || pop_vec[push_idx]);
    assign overflow = push_one && !push_ok;
    assign push_vec = push_ok ? from_tx.credit_vc_target : '0;

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            cnt_nxt[v] = cnt[v];
            if (push_vec[v] && !pop_vec[v]) cnt_nxt[v] = cnt[v] + CNT_W'(1);
            else if (!push_vec[v] && pop_vec[v]) cnt_nxt[v] = cnt[v] - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_W; v++) begin
                cnt[v]    <= '0;
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
            rr_ptr                       <= '0;
            locked                       <= 1'b0;
            lock_idx                     <= '0;
            from_tx.credit_vc_credit_gnt <= '0;
            err_overflow                 <= 1'b0;
            err_multihot                 <= 1'b0;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                cnt[v] <= cnt_nxt[v];
                if (push_vec[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                if (pop_vec[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
            end
            locked   <= out_valid && !out_ready;
            lock_idx <= sel_idx;
            if (pop) rr_ptr <= (sel_idx == IDX_W'(VC_W - 1)) ? '0 : sel_idx + IDX_W'(1);
            from_tx.credit_vc_credit_gnt <= pop_vec;
            err_overflow <= err_overflow | overflow;
            err_multihot <= err_multihot | multihot;
        end
    end

    // NOTE: storage is not reset; counts and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_W; v++) begin
            if (push_vec[v]) mem[v][wr_ptr[v]] <= from_tx.credit_packet;
        end
    end

`ifdef NOC_CREDIT_RX_BUFFER_OCC_EN
    always_comb begin
        for (int v = 0; v < VC_W; v++) occupancy[v] = cnt[v];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_max <= '0;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                if (cnt_nxt[v] > occ_max[v]) occ_max[v] <= cnt_nxt[v];
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_credit_rx_buffer.sv
// Directed bench for noc_credit_rx_buffer with VC_W=2, A_W=D_W=8, DEPTH=4.
module tb_noc_credit_rx_buffer;

    localparam int VC_W  = 2;
    localparam int A_W   = 8;
    localparam int D_W   = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_if #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W)) link ();

    logic            out_valid, out_ready, out_last, err_overflow, err_multihot;
    logic [VC_W-1:0] out_vc;
    logic [A_W-1:0]  out_addr;
    logic [D_W-1:0]  out_data;
`ifdef NOC_CREDIT_RX_BUFFER_OCC_EN
    logic [VC_W-1:0][$clog2(DEPTH+1)-1:0] occupancy, occ_max;
`endif

    int checks = 0;
    int errors = 0;

    noc_credit_rx_buffer #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .from_tx      (link.receiver),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vc       (out_vc),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_last     (out_last),
        .err_overflow (err_overflow),
        .err_multihot (err_multihot)
`ifdef NOC_CREDIT_RX_BUFFER_OCC_EN
        ,
        .occupancy    (occupancy),
        .occ_max      (occ_max)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [VC_W-1:0] vc, input logic [A_W-1:0] a,
                        input logic [D_W-1:0] d, input logic l);
        link.credit_vc_target = vc;
        link.credit_packet    = {l, a, d};
        step();
        link.credit_vc_target = '0;
    endtask

    task automatic test_reset();
        link.credit_vc_target = '0;
        link.credit_packet    = '0;
        out_ready             = 1'b0;
        rst                   = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_vc !== 2'b00) begin errors++; $display("FAIL reset_vc: got %b want 00", out_vc); end
        checks++; if (link.credit_vc_credit_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", link.credit_vc_credit_gnt); end
        checks++; if ({err_overflow, err_multihot} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {err_overflow, err_multihot}); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        out_ready             = 1'b1;
        link.credit_vc_target = 2'b01;
        link.credit_packet    = {1'b1, 8'h03, 8'hAB};
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_writethrough: got %b want 0", out_valid); end
        step();
        link.credit_vc_target = '0;
        checks++; if ({out_valid, out_vc, out_addr, out_data, out_last} !== {1'b1, 2'b01, 8'h03, 8'hAB, 1'b1})
            begin errors++; $display("FAIL single_present: got v=%b vc=%b a=%h d=%h l=%b want v=1 vc=01 a=03 d=ab l=1", out_valid, out_vc, out_addr, out_data, out_last); end
        checks++; if (link.credit_vc_credit_gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_early: got %b want 00", link.credit_vc_credit_gnt); end
        step();
        checks++; if (link.credit_vc_credit_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", link.credit_vc_credit_gnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %b want 0", out_valid); end
        step();
        checks++; if (link.credit_vc_credit_gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_pulse: got %b want 00", link.credit_vc_credit_gnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'b10, 8'(i), 8'(8'h10 + i), i == 3);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({out_valid, out_vc, out_addr, out_data, out_last, link.credit_vc_credit_gnt} !== {1'b1, 2'b10, 8'h00, 8'h10, 1'b0, 2'b00})
                begin errors++; $display("FAIL bp_stall[%0d]: got v=%b vc=%b a=%h d=%h gnt=%b want v=1 vc=10 a=00 d=10 gnt=00", c, out_valid, out_vc, out_addr, out_data, link.credit_vc_credit_gnt); end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_vc, out_addr, out_data, out_last} !== {1'b1, 2'b10, 8'(i), 8'(8'h10 + i), i == 3})
                begin errors++; $display("FAIL bp_drain[%0d]: got v=%b vc=%b a=%h d=%h l=%b want d=%h", i, out_valid, out_vc, out_addr, out_data, out_last, 8'h10 + i); end
            step();
            checks++; if (link.credit_vc_credit_gnt !== 2'b10) begin errors++; $display("FAIL bp_gnt[%0d]: got %b want 10", i, link.credit_vc_credit_gnt); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
        step();
        checks++; if (link.credit_vc_credit_gnt !== 2'b00) begin errors++; $display("FAIL bp_gnt_idle: got %b want 00", link.credit_vc_credit_gnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_vc;
        logic [7:0] exp_d;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(2'b01, 8'h00, 8'(8'h20 + i), 1'b0);
            push(2'b10, 8'h00, 8'(8'h30 + i), 1'b0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_vc = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d  = 8'(((i % 2 == 0) ? 8'h20 : 8'h30) + i / 2);
            checks++;
            if ({out_valid, out_vc, out_data} !== {1'b1, exp_vc, exp_d})
                begin errors++; $display("FAIL rr[%0d]: got v=%b vc=%b d=%h want v=1 vc=%b d=%h", i, out_valid, out_vc, out_data, exp_vc, exp_d); end
            step();
            checks++; if (link.credit_vc_credit_gnt !== exp_vc) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, link.credit_vc_credit_gnt, exp_vc); end
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_full_pushpop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'b01, 8'h00, 8'(8'h50 + i), 1'b0);
        checks++; if (out_data !== 8'h50) begin errors++; $display("FAIL full_head: got %h want 50", out_data); end
        out_ready = 1'b1;
        push(2'b01, 8'h00, 8'h54, 1'b0);
        out_ready = 1'b0;
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_err: got %b want 0", err_overflow); end
        checks++; if ({out_valid, out_data} !== {1'b1, 8'h51}) begin errors++; $display("FAIL full_pushpop_head: got v=%b d=%h want v=1 d=51", out_valid, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_vc, out_data} !== {1'b1, 2'b01, 8'(8'h51 + i)})
                begin errors++; $display("FAIL full_drain[%0d]: got v=%b vc=%b d=%h want d=%h", i, out_valid, out_vc, out_data, 8'h51 + i); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_count: got valid=%b after 4 pops want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int n;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'b01, 8'h00, 8'(8'h40 + i), 1'b0);
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
        push(2'b01, 8'h00, 8'h44, 1'b0);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== 8'(8'h40 + n)) begin errors++; $display("FAIL ovf_data[%0d]: got %h want %h", n, out_data, 8'h40 + n); end
                n++;
            end
            step();
        end
        out_ready = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL ovf_count: got %0d flits want 4", n); end
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", err_overflow); end
    endtask

    task automatic test_multihot_reset();
        out_ready             = 1'b0;
        link.credit_vc_target = 2'b11;
        link.credit_packet    = {1'b0, 8'hEE, 8'hEE};
        step();
        link.credit_vc_target = '0;
        checks++; if (err_multihot !== 1'b1) begin errors++; $display("FAIL mh_flag: got %b want 1", err_multihot); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mh_nowrite: got valid=%b want 0", out_valid); end
        for (int i = 0; i < 3; i++) push(2'b10, 8'h00, 8'(8'h60 + i), 1'b0);
        out_ready = 1'b1;
        step();
        checks++; if (link.credit_vc_credit_gnt !== 2'b10) begin errors++; $display("FAIL rst_pre_gnt: got %b want 10", link.credit_vc_credit_gnt); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_vc, link.credit_vc_credit_gnt, err_overflow, err_multihot} !== 7'b0)
            begin errors++; $display("FAIL rst_async: got v=%b vc=%b gnt=%b ovf=%b mh=%b want all 0", out_valid, out_vc, link.credit_vc_credit_gnt, err_overflow, err_multihot); end
        out_ready = 1'b0;
        step();
        #2 rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_empty: got %b want 0", out_valid); end
        push(2'b10, 8'h07, 8'h77, 1'b1);
        checks++;
        if ({out_valid, out_vc, out_addr, out_data, out_last} !== {1'b1, 2'b10, 8'h07, 8'h77, 1'b1})
            begin errors++; $display("FAIL rst_after: got v=%b vc=%b a=%h d=%h l=%b want v=1 vc=10 a=07 d=77 l=1", out_valid, out_vc, out_addr, out_data, out_last); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_full_pushpop();
        test_overflow();
        test_multihot_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
